// File: rtl/axi_arb_pkg.sv
// Shared types for the AXI4-Lite IFU/LSU arbiter: FSM states, grant owner
// and AXI response codes.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_IFU = 2'd1,
        RD_LSU = 2'd2,
        WR_LSU = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_IFU = 1'b0,
        GNT_LSU = 1'b1
    } arb_gnt_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_arbiter.sv
// Two-master (IFU read, LSU read/write) to one AXI4-Lite slave arbiter with a
// single outstanding transaction and IFU-after-LSU fairness.
module axi_lite_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [ADDR_W-1:0]   ifu_araddr,
    input  logic                ifu_arvalid,
    output logic                ifu_arready,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic [1:0]          ifu_rresp,
    output logic                ifu_rvalid,
    input  logic                ifu_rready,

    input  logic [ADDR_W-1:0]   lsu_araddr,
    input  logic                lsu_arvalid,
    output logic                lsu_arready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic [1:0]          lsu_rresp,
    output logic                lsu_rvalid,
    input  logic                lsu_rready,
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic                lsu_awvalid,
    output logic                lsu_awready,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    input  logic                lsu_wvalid,
    output logic                lsu_wready,
    output logic [1:0]          lsu_bresp,
    output logic                lsu_bvalid,
    input  logic                lsu_bready,

    output logic [ADDR_W-1:0]   mem_araddr,
    output logic                mem_arvalid,
    input  logic                mem_arready,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic [1:0]          mem_rresp,
    input  logic                mem_rvalid,
    output logic                mem_rready,
    output logic [ADDR_W-1:0]   mem_awaddr,
    output logic                mem_awvalid,
    input  logic                mem_awready,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic                mem_wvalid,
    input  logic                mem_wready,
    input  logic [1:0]          mem_bresp,
    input  logic                mem_bvalid,
    output logic                mem_bready
);

    arb_state_e state, state_nxt;
    arb_gnt_e   last_gnt;
    logic       ar_done, aw_done, w_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            last_gnt <= GNT_IFU;
            ar_done  <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt == IDLE) begin
                ar_done <= 1'b0;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (mem_arvalid && mem_arready) ar_done <= 1'b1;
                if (mem_awvalid && mem_awready) aw_done <= 1'b1;
                if (mem_wvalid  && mem_wready)  w_done  <= 1'b1;
            end
            // Fairness is keyed on the owner of the last completed transaction.
            if (state != IDLE && state_nxt == IDLE)
                last_gnt <= (state == RD_IFU) ? GNT_IFU : GNT_LSU;
        end
    end

    // Everything below decodes the registered state, so nothing from a master
    // valid reaches the slave while IDLE.
    always_comb begin
        state_nxt   = state;
        ifu_arready = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = 2'b00;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = 2'b00;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bresp   = 2'b00;
        lsu_bvalid  = 1'b0;
        mem_araddr  = '0;
        mem_arvalid = 1'b0;
        mem_rready  = 1'b0;
        mem_awaddr  = '0;
        mem_awvalid = 1'b0;
        mem_wdata   = '0;
        mem_wstrb   = '0;
        mem_wvalid  = 1'b0;
        mem_bready  = 1'b0;

        case (state)
            IDLE: begin
                if (ifu_arvalid && last_gnt == GNT_LSU) state_nxt = RD_IFU;
                else if (lsu_awvalid && lsu_wvalid)     state_nxt = WR_LSU;
                else if (lsu_arvalid)                   state_nxt = RD_LSU;
                else if (ifu_arvalid)                   state_nxt = RD_IFU;
            end
            RD_IFU: begin
                mem_araddr  = ifu_araddr;
                mem_arvalid = ifu_arvalid && !ar_done;
                ifu_arready = mem_arready && !ar_done;
                ifu_rdata   = mem_rdata;
                ifu_rresp   = mem_rresp;
                ifu_rvalid  = mem_rvalid;
                mem_rready  = ifu_rready;
                if (mem_rvalid && mem_rready) state_nxt = IDLE;
            end
            RD_LSU: begin
                mem_araddr  = lsu_araddr;
                mem_arvalid = lsu_arvalid && !ar_done;
                lsu_arready = mem_arready && !ar_done;
                lsu_rdata   = mem_rdata;
                lsu_rresp   = mem_rresp;
                lsu_rvalid  = mem_rvalid;
                mem_rready  = lsu_rready;
                if (mem_rvalid && mem_rready) state_nxt = IDLE;
            end
            WR_LSU: begin
                mem_awaddr  = lsu_awaddr;
                mem_awvalid = lsu_awvalid && !aw_done;
                lsu_awready = mem_awready && !aw_done;
                mem_wdata   = lsu_wdata;
                mem_wstrb   = lsu_wstrb;
                mem_wvalid  = lsu_wvalid && !w_done;
                lsu_wready  = mem_wready && !w_done;
                lsu_bresp   = mem_bresp;
                lsu_bvalid  = mem_bvalid;
                mem_bready  = lsu_bready;
                if (mem_bvalid && mem_bready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A granted master must keep valid up until its own handshake.
    a_ifu_ar_hold: assert property (@(posedge clk) disable iff (!rst)
        (state == RD_IFU && !ar_done) |-> ifu_arvalid);
    a_lsu_ar_hold: assert property (@(posedge clk) disable iff (!rst)
        (state == RD_LSU && !ar_done) |-> lsu_arvalid);
    a_lsu_aw_hold: assert property (@(posedge clk) disable iff (!rst)
        (state == WR_LSU && !aw_done) |-> lsu_awvalid);
    a_lsu_w_hold: assert property (@(posedge clk) disable iff (!rst)
        (state == WR_LSU && !w_done) |-> lsu_wvalid);

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter: reactive slave model, handshake monitor
// and hand-computed expectations.
module tb_axi_lite_arbiter;
    import axi_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] ifu_araddr = '0;
    logic          ifu_arvalid = 1'b0, ifu_arready;
    logic [DW-1:0] ifu_rdata;
    logic [1:0]    ifu_rresp;
    logic          ifu_rvalid, ifu_rready = 1'b1;
    logic [AW-1:0] lsu_araddr = '0;
    logic          lsu_arvalid = 1'b0, lsu_arready;
    logic [DW-1:0] lsu_rdata;
    logic [1:0]    lsu_rresp;
    logic          lsu_rvalid, lsu_rready = 1'b1;
    logic [AW-1:0] lsu_awaddr = '0;
    logic          lsu_awvalid = 1'b0, lsu_awready;
    logic [DW-1:0] lsu_wdata = '0;
    logic [SW-1:0] lsu_wstrb = '0;
    logic          lsu_wvalid = 1'b0, lsu_wready;
    logic [1:0]    lsu_bresp;
    logic          lsu_bvalid, lsu_bready = 1'b1;
    logic [AW-1:0] mem_araddr, mem_awaddr;
    logic          mem_arvalid, mem_arready, mem_rready;
    logic [DW-1:0] mem_rdata, mem_wdata;
    logic [1:0]    mem_rresp, mem_bresp;
    logic          mem_rvalid, mem_awvalid, mem_awready;
    logic [SW-1:0] mem_wstrb;
    logic          mem_wvalid, mem_wready, mem_bvalid, mem_bready;

    axi_lite_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .mem_araddr(mem_araddr), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
        .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
        .mem_awaddr(mem_awaddr), .mem_awvalid(mem_awvalid), .mem_awready(mem_awready),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
        .mem_bresp(mem_bresp), .mem_bvalid(mem_bvalid), .mem_bready(mem_bready)
    );

    // Slave model: AR always ready, R after r_lat+1 cycles, AW/W ready after
    // their own latency, B one cycle after both land.
    int            r_lat = 0, aw_lat = 0, w_lat = 0;
    logic [DW-1:0] r_data = '0;
    logic [1:0]    r_resp = OKAY, b_resp = OKAY;
    int            rd_cnt, aw_cnt, w_cnt;
    logic          rd_pend, aw_got, w_got;

    assign mem_arready = 1'b1;
    assign mem_awready = mem_awvalid && (aw_cnt >= aw_lat);
    assign mem_wready  = mem_wvalid && (w_cnt >= w_lat);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pend <= 1'b0; rd_cnt <= 0; mem_rvalid <= 1'b0; mem_rdata <= '0; mem_rresp <= 2'b00;
            aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            mem_bvalid <= 1'b0; mem_bresp <= 2'b00;
        end else begin
            if (mem_rvalid && mem_rready) mem_rvalid <= 1'b0;
            if (mem_arvalid && mem_arready) begin
                rd_pend <= 1'b1; rd_cnt <= r_lat;
            end else if (rd_pend) begin
                if (rd_cnt == 0) begin
                    rd_pend <= 1'b0; mem_rvalid <= 1'b1; mem_rdata <= r_data; mem_rresp <= r_resp;
                end else rd_cnt <= rd_cnt - 1;
            end
            if (mem_awvalid && mem_awready) begin aw_cnt <= 0; aw_got <= 1'b1; end
            else if (mem_awvalid) aw_cnt <= aw_cnt + 1;
            if (mem_wvalid && mem_wready) begin w_cnt <= 0; w_got <= 1'b1; end
            else if (mem_wvalid) w_cnt <= w_cnt + 1;
            if (mem_bvalid && mem_bready) mem_bvalid <= 1'b0;
            else if (aw_got && w_got) begin
                mem_bvalid <= 1'b1; mem_bresp <= b_resp; aw_got <= 1'b0; w_got <= 1'b0;
            end
        end
    end

    // Handshake monitor
    int n_ar = 0, n_aw = 0, n_w = 0, n_b = 0, n_ifu_r = 0, n_lsu_r = 0, n_lsu_rv = 0, n_leak = 0;
    int cyc = 0, aw_cyc = 0, w_cyc = 0;
    logic [AW-1:0] glog[$];
    logic [DW-1:0] ifu_rd_seen = '0, lsu_rd_seen = '0, w_seen = '0;
    logic [1:0]    ifu_rr_seen = '0, lsu_rr_seen = '0, b_seen = '0;
    logic [SW-1:0] ws_seen = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            if (mem_arvalid && mem_arready) begin n_ar <= n_ar + 1; glog.push_back(mem_araddr); end
            if (mem_awvalid && mem_awready) begin n_aw <= n_aw + 1; aw_cyc <= cyc; glog.push_back(mem_awaddr); end
            if (mem_wvalid && mem_wready) begin
                n_w <= n_w + 1; w_cyc <= cyc; w_seen <= mem_wdata; ws_seen <= mem_wstrb;
            end
            if (ifu_rvalid && ifu_rready) begin n_ifu_r <= n_ifu_r + 1; ifu_rd_seen <= ifu_rdata; ifu_rr_seen <= ifu_rresp; end
            if (lsu_rvalid && lsu_rready) begin n_lsu_r <= n_lsu_r + 1; lsu_rd_seen <= lsu_rdata; lsu_rr_seen <= lsu_rresp; end
            if (lsu_bvalid && lsu_bready) begin n_b <= n_b + 1; b_seen <= lsu_bresp; end
            if (lsu_rvalid) n_lsu_rv <= n_lsu_rv + 1;
            if ((ifu_rvalid && (lsu_rvalid || lsu_rdata != '0)) ||
                (lsu_rvalid && (ifu_rvalid || ifu_rdata != '0))) n_leak <= n_leak + 1;
        end
    end

    int n_chk = 0, n_err = 0;
    int b_ar, b_aw, b_w, b_b, b_ifu_r, b_lsu_r, b_lsu_rv;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_ar = n_ar; b_aw = n_aw; b_w = n_w; b_b = n_b;
        b_ifu_r = n_ifu_r; b_lsu_r = n_lsu_r; b_lsu_rv = n_lsu_rv;
        glog.delete();
    endtask

    task automatic ifu_rd(input logic [AW-1:0] a);
        bit hs = 1'b0;
        ifu_araddr = a; ifu_arvalid = 1'b1;
        for (int i = 0; i < 60 && !hs; i++) begin
            @(negedge clk); hs = ifu_arready;
            @(posedge clk); #1;
        end
        ifu_arvalid = 1'b0;
        chk("ifu_ar_hs", hs, 1);
    endtask

    task automatic lsu_rd(input logic [AW-1:0] a);
        bit hs = 1'b0;
        lsu_araddr = a; lsu_arvalid = 1'b1;
        for (int i = 0; i < 60 && !hs; i++) begin
            @(negedge clk); hs = lsu_arready;
            @(posedge clk); #1;
        end
        lsu_arvalid = 1'b0;
        chk("lsu_ar_hs", hs, 1);
    endtask

    // hold=1 keeps AW/W valid asserted until B, so a lost done flag shows up
    // as a repeated slave handshake.
    task automatic lsu_wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input bit hold);
        bit awh = 1'b0, wh = 1'b0, bh = 1'b0, fin = 1'b0, a_now, w_now, b_now;
        lsu_awaddr = a; lsu_wdata = d; lsu_wstrb = s;
        lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
        for (int i = 0; i < 60 && !fin; i++) begin
            @(negedge clk); a_now = lsu_awready; w_now = lsu_wready; b_now = lsu_bvalid;
            @(posedge clk); #1;
            if (a_now) begin awh = 1'b1; if (!hold) lsu_awvalid = 1'b0; end
            if (w_now) begin wh = 1'b1; if (!hold) lsu_wvalid = 1'b0; end
            if (b_now) bh = 1'b1;
            fin = hold ? bh : (awh && wh);
        end
        lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
        chk("lsu_wr_hs", {awh, wh}, 2'b11);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hs;
        // Reset: outputs forced low even with every master requesting
        ifu_araddr = 32'h8000_0000; lsu_araddr = 32'h9000_0000; lsu_awaddr = 32'h8000_1000;
        lsu_wdata = 32'hFFFF_FFFF; ifu_arvalid = 1'b1; lsu_arvalid = 1'b1;
        lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("rst_mem_valid", {mem_arvalid, mem_awvalid, mem_wvalid}, 0);
        chk("rst_mem_ready", {mem_rready, mem_bready}, 0);
        chk("rst_m_ready", {ifu_arready, lsu_arready, lsu_awready, lsu_wready}, 0);
        chk("rst_m_valid", {ifu_rvalid, lsu_rvalid, lsu_bvalid}, 0);
        chk("rst_addr", {mem_araddr, mem_awaddr}, 0);
        chk("rst_wdata", mem_wdata, 0);
        ifu_arvalid = 1'b0; lsu_arvalid = 1'b0; lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // IFU read, 3-cycle slave latency, arvalid held until R
        snap(); r_lat = 2; r_data = 32'h0000_0413; r_resp = OKAY;
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1;
        @(negedge clk); chk("idle_ar_gated", mem_arvalid, 0);
        @(negedge clk); chk("ar_fwd_valid", mem_arvalid, 1);
        chk("ar_fwd_addr", mem_araddr, 32'h8000_0000);
        hs = 1'b0;
        for (int i = 0; i < 40 && !hs; i++) begin
            @(negedge clk); hs = ifu_rvalid;
            @(posedge clk); #1;
        end
        ifu_arvalid = 1'b0;
        chk("ifu_r_seen", hs, 1);
        @(negedge clk);
        chk("ifu_ar_once", n_ar - b_ar, 1);
        chk("ifu_r_once", n_ifu_r - b_ifu_r, 1);
        chk("ifu_rdata", ifu_rd_seen, 32'h0000_0413);
        chk("ifu_rresp", ifu_rr_seen, OKAY);
        chk("lsu_rvalid_quiet", n_lsu_rv - b_lsu_rv, 0);
        chk("idle_rready", mem_rready, 0);

        // Same-cycle IFU read and LSU write with last grant IFU: write first
        @(posedge clk); #1;
        snap(); r_lat = 1; r_data = 32'h1234_5678;
        fork
            ifu_rd(32'h8000_0010);
            lsu_wr(32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 1'b0);
        join
        repeat (10) @(posedge clk); #1;
        chk("order_len", glog.size(), 2);
        chk("order_wr_first", glog[0], 32'h8000_1000);
        chk("order_rd_second", glog[1], 32'h8000_0010);
        chk("wr_data", w_seen, 32'hDEAD_BEEF);
        chk("wr_strb", ws_seen, 4'hF);
        chk("wr_b_once", n_b - b_b, 1);
        chk("rd_after_wr", ifu_rd_seen, 32'h1234_5678);

        // Back-to-back LSU reads with IFU pending: LSU, IFU, LSU
        snap();
        fork
            ifu_rd(32'h8000_0040);
            begin
                lsu_rd(32'h9000_0000);
                lsu_rd(32'h9000_0004);
            end
        join
        repeat (10) @(posedge clk); #1;
        chk("alt_len", glog.size(), 3);
        chk("alt_0_lsu", glog[0], 32'h9000_0000);
        chk("alt_1_ifu", glog[1], 32'h8000_0040);
        chk("alt_2_lsu", glog[2], 32'h9000_0004);
        chk("alt_lsu_r", n_lsu_r - b_lsu_r, 2);
        chk("alt_ifu_r", n_ifu_r - b_ifu_r, 1);

        // W accepted two cycles before AW, LSU holds valids until B
        snap(); aw_lat = 2; w_lat = 0; b_resp = OKAY;
        lsu_wr(32'h8000_2000, 32'h0BAD_F00D, 4'h3, 1'b1);
        @(negedge clk);
        chk("split_aw_once", n_aw - b_aw, 1);
        chk("split_w_once", n_w - b_w, 1);
        chk("split_b_once", n_b - b_b, 1);
        chk("split_w_lead", aw_cyc - w_cyc, 2);
        chk("split_wdata", w_seen, 32'h0BAD_F00D);
        chk("split_bresp", b_seen, OKAY);
        aw_lat = 0;
        @(posedge clk); #1;

        // SLVERR passes through once, no retry
        snap(); r_lat = 1; r_resp = SLVERR; r_data = 32'hBAD0_0BAD;
        lsu_rd(32'h9000_0200);
        repeat (10) @(posedge clk); #1;
        chk("slverr_r_once", n_lsu_r - b_lsu_r, 1);
        chk("slverr_resp", lsu_rr_seen, 2'b10);
        chk("slverr_data", lsu_rd_seen, 32'hBAD0_0BAD);
        chk("slverr_no_retry", n_ar - b_ar, 1);

        // Reset while RD_LSU waits on R
        snap(); r_lat = 20; r_resp = OKAY;
        lsu_rd(32'h9000_0300);
        @(negedge clk); chk("pre_rst_rready", mem_rready, 1);
        chk("pre_rst_araddr", mem_araddr, 32'h9000_0300);
        #1; lsu_araddr = 32'h9000_0300; lsu_arvalid = 1'b1; rst = 1'b0;
        #1;
        chk("rst_async_rready", mem_rready, 0);
        chk("rst_async_arvalid", mem_arvalid, 0);
        chk("rst_async_araddr", mem_araddr, 0);
        chk("rst_async_arready", lsu_arready, 0);
        @(posedge clk); #1; lsu_arvalid = 1'b0;
        @(negedge clk); rst = 1'b1;
        repeat (25) @(posedge clk); #1;
        chk("rst_no_replay_ar", n_ar - b_ar, 1);
        chk("rst_no_late_r", n_lsu_r - b_lsu_r, 0);
        r_lat = 2; r_data = 32'h0000_0417;
        ifu_rd(32'h8000_0080);
        repeat (10) @(posedge clk); #1;
        chk("post_rst_ifu_r", n_ifu_r - b_ifu_r, 1);
        chk("post_rst_rdata", ifu_rd_seen, 32'h0000_0417);

        chk("no_route_leak", n_leak, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/axi_lite_arbiter.md
AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all AR/AW channels.
REQ-002 Parameter DATA_W, default 32, data width of R/W channels; the strobe width SHALL be DATA_W/8.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 ifu_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  instruction-fetch read-address channel (master 0).
REQ-006 ifu_rdata/rresp/rvalid/rready  out/out/out/in  DATA_W/2/1/1  instruction-fetch read-data channel.
REQ-007 lsu_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  load/store-unit read-address channel (master 1).
REQ-008 lsu_rdata/rresp/rvalid/rready  out/out/out/in  DATA_W/2/1/1  load/store-unit read-data channel.
REQ-009 lsu_awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  load/store-unit write-address channel.
REQ-010 lsu_wdata/wstrb/wvalid/wready  in/in/in/out  DATA_W/DATA_W/8/1/1  load/store-unit write-data channel.
REQ-011 lsu_bresp/bvalid/bready  out/out/in  2/1/1  load/store-unit write-response channel.
REQ-012 mem_ar*, mem_r*, mem_aw*, mem_w*, mem_b*  mirrored directions, same widths  single downstream AXI4-Lite slave port.

Function
REQ-013 FSM states: IDLE, RD_IFU, RD_LSU, WR_LSU; exactly one transaction outstanding at a time.
REQ-014 IDLE selection order: LSU write (lsu_awvalid & lsu_wvalid), then LSU read, then IFU read.
REQ-015 Fairness: if IFU arvalid is pending and the previous completed grant was LSU, IFU SHALL win over LSU read or write.
REQ-016 Grant latency: a request seen in IDLE at cycle N is registered as the grant; the slave sees valid at cycle N+1 at the earliest.
REQ-017 RD_x: forward the granted master's araddr and arvalid to mem_ar until the mem_ar handshake; then hold mem_arvalid=0 (ar_done flag).
REQ-018 RD_x: route mem_rdata, mem_rresp and mem_rvalid only to the granted master, and that master's rready to mem_rready; on the R handshake, return to IDLE.
REQ-019 WR_LSU: forward AW and W independently, each with its own done flag, so that each channel issues exactly one handshake in either order.
REQ-020 WR_LSU: route B to the LSU; on the B handshake, return to IDLE.
REQ-021 Non-granted master outputs: arready, awready, wready, rvalid and bvalid SHALL be 0, and rdata SHALL be 0.
REQ-022 In IDLE, all mem_* valid and ready outputs SHALL be 0; no combinational path from master valid to mem valid while in IDLE.
REQ-023 rresp and bresp SHALL pass through unchanged, including SLVERR/DECERR; the arbiter SHALL NOT retry.
REQ-024 Back-to-back transactions: minimum one IDLE cycle between the completing handshake and the next grant.
REQ-025 A master deasserting valid before its handshake is a protocol violation; the grant SHALL be held and an assertion SHALL flag it.

Reset
REQ-026 While rst=0: state=IDLE, done flags=0, last-grant=IFU, and all valid/ready outputs=0, asynchronously.
REQ-027 Reset asserted mid-transaction SHALL abandon that transaction; after release, the FSM starts in IDLE with no replay.
REQ-028 Data outputs (rdata, addr, wdata) SHALL be 0 during reset.

Structure
REQ-029 Shared package axi_arb_pkg: state enum, grant enum {GNT_IFU, GNT_LSU}, AXI resp constants OKAY/EXOKAY/SLVERR/DECERR.
REQ-030 Single module with no sub-modules; the channel muxing is combinational from the registered state.

Verification
REQ-031 IFU read 0x8000_0000, slave returns 0x0000_0413 after 3 cycles -> ifu_rdata=0x0000_0413 with rresp OKAY, lsu_rvalid stays 0, FSM returns to IDLE.
REQ-032 IFU read and LSU write (addr 0x8000_1000, data 0xDEAD_BEEF, strb 0xF) requested in the same cycle with last-grant=IFU -> write is issued first, then the IFU read.
REQ-033 LSU reads issued back-to-back while IFU arvalid stays high -> grants alternate LSU, IFU, LSU.
REQ-034 Slave accepts W two cycles before AW -> exactly one mem_w handshake and one mem_aw handshake, then one bvalid to the LSU.
REQ-035 rst driven low while in RD_LSU, waiting on R -> all outputs are 0 in the same cycle; after release, an IFU read completes normally.
REQ-036 Slave returns rresp=SLVERR for an LSU read -> lsu_rresp=2'b10 is delivered once, with no retry.
